// File: rtl/player_laser_ctrl.sv
// Player ship and laser game state, advanced once per frame pulse during blanking.
// Buttons are synchronized; a fire press arms a single shot that launches on the next frame.
module player_laser_ctrl #(
    parameter int RES_H       = 640,
    parameter int PLAYER_W    = 26,
    parameter int PLAYER_Y    = 440,
    parameter int PLAYER_STEP = 2,
    parameter int PROJ_W      = 2,
    parameter int PROJ_H      = 8,
    parameter int LASER_STEP  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_fire,
    input  logic       laser_hit,
    output logic [9:0] player_x,
    output logic [9:0] player_y,
    output logic       laser_active,
    output logic [9:0] laser_x,
    output logic [9:0] laser_y
);

    localparam logic [9:0] X_MAX     = 10'(RES_H - PLAYER_W);
    localparam logic [9:0] X_RESET   = 10'((RES_H - PLAYER_W) / 2);
    localparam logic [9:0] P_STEP    = 10'(PLAYER_STEP);
    localparam logic [9:0] L_STEP    = 10'(LASER_STEP);
    localparam logic [9:0] SPAWN_OFS = 10'(PLAYER_W / 2 - PROJ_W / 2);
    localparam logic [9:0] SPAWN_Y   = 10'(PLAYER_Y - PROJ_H);

    typedef enum logic {IDLE, FLY} state_t;

    state_t     state;
    logic [1:0] left_sync;
    logic [1:0] right_sync;
    logic [1:0] fire_sync;
    logic       fire_prev;
    logic       fire_req;
    logic       fire_edge;
    logic       move_left;
    logic       move_right;

    assign player_y   = 10'(PLAYER_Y);
    assign fire_edge  = fire_sync[1] & ~fire_prev;
    assign move_left  = left_sync[1] & ~right_sync[1];
    assign move_right = right_sync[1] & ~left_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_sync  <= '0;
            right_sync <= '0;
            fire_sync  <= '0;
            fire_prev  <= 1'b0;
        end else begin
            left_sync  <= {left_sync[0], btn_left};
            right_sync <= {right_sync[0], btn_right};
            fire_sync  <= {fire_sync[0], btn_fire};
            fire_prev  <= fire_sync[1];
        end
    end

    // Saturating move; the subtract is guarded so it can never wrap below zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            player_x <= X_RESET;
        end else if (frame) begin
            if (move_left)
                player_x <= (player_x < P_STEP) ? 10'd0 : player_x - P_STEP;
            else if (move_right)
                player_x <= (player_x > X_MAX - P_STEP) ? X_MAX : player_x + P_STEP;
        end
    end

    // Spawn reads player_x before this frame's move lands (same edge).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            laser_active <= 1'b0;
            laser_x      <= '0;
            laser_y      <= '0;
            fire_req     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame && fire_req) begin
                        state        <= FLY;
                        laser_active <= 1'b1;
                        laser_x      <= player_x + SPAWN_OFS;
                        laser_y      <= SPAWN_Y;
                        fire_req     <= 1'b0;
                    end else if (fire_edge) begin
                        fire_req <= 1'b1;
                    end
                end
                FLY: begin
                    fire_req <= 1'b0;
                    if (laser_hit) begin
                        state        <= IDLE;
                        laser_active <= 1'b0;
                    end else if (frame) begin
                        if (laser_y < L_STEP) begin
                            state        <= IDLE;
                            laser_active <= 1'b0;
                        end else begin
                            laser_y <= laser_y - L_STEP;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    laser_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_laser_ctrl.sv
// Bench for player_laser_ctrl: directed scenarios plus random buttons/frames/hits,
// checked every cycle against a frame-level model of the ship and laser.
module tb_player_laser_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_fire = 1'b0;
    logic       laser_hit = 1'b0;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic       laser_active;
    logic [9:0] laser_x;
    logic [9:0] laser_y;

    int checks = 0;
    int failures = 0;

    // model state
    int m_px, m_active, m_lx, m_ly, m_req;
    logic [3:0] hl, hr, hf;

    player_laser_ctrl dut (
        .clk(clk), .rst(rst), .frame(frame),
        .btn_left(btn_left), .btn_right(btn_right), .btn_fire(btn_fire),
        .laser_hit(laser_hit),
        .player_x(player_x), .player_y(player_y),
        .laser_active(laser_active), .laser_x(laser_x), .laser_y(laser_y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_px = 307; m_active = 0; m_lx = 0; m_ly = 0; m_req = 0;
        hl = '0; hr = '0; hf = '0;
    endtask

    // Buttons take effect two samples late; a fire press is a 0->1 seen in that delayed stream.
    task automatic model_step();
        logic sl, sr, fe;
        int   old_px;
        hl = {hl[2:0], btn_left};
        hr = {hr[2:0], btn_right};
        hf = {hf[2:0], btn_fire};
        sl = hl[2];
        sr = hr[2];
        fe = hf[2] & ~hf[3];
        old_px = m_px;
        if (frame && sl && !sr) m_px = (m_px - 2 < 0) ? 0 : m_px - 2;
        if (frame && sr && !sl) m_px = (m_px + 2 > 614) ? 614 : m_px + 2;
        if (m_active == 0) begin
            if (frame && m_req == 1) begin
                m_active = 1; m_lx = old_px + 12; m_ly = 432; m_req = 0;
            end else if (fe) begin
                m_req = 1;
            end
        end else begin
            m_req = 0;
            if (laser_hit) m_active = 0;
            else if (frame) begin
                if (m_ly < 4) m_active = 0;
                else m_ly = m_ly - 4;
            end
        end
    endtask

    task automatic compare_all();
        chk("player_x", int'(player_x), m_px);
        chk("player_y", int'(player_y), 440);
        chk("laser_active", int'(laser_active), m_active);
        chk("laser_x", int'(laser_x), m_lx);
        chk("laser_y", int'(laser_y), m_ly);
    endtask

    task automatic cycle(input logic l, input logic r, input logic f,
                         input logic fr, input logic hit);
        @(negedge clk);
        btn_left = l; btn_right = r; btn_fire = f; frame = fr; laser_hit = hit;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic frames(input int n, input logic l, input logic r);
        repeat (n) begin
            repeat (3) cycle(l, r, 1'b0, 1'b0, 1'b0);
            cycle(l, r, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic press_fire();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asserted away from the clock edge so the outputs must clear asynchronously.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        btn_left = 0; btn_right = 0; btn_fire = 0; frame = 0; laser_hit = 0;
        #1;
        chk("rst_player_x", int'(player_x), 307);
        chk("rst_player_y", int'(player_y), 440);
        chk("rst_laser_active", int'(laser_active), 0);
        chk("rst_laser_x", int'(laser_x), 0);
        chk("rst_laser_y", int'(laser_y), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic l, r, f;
        model_reset();
        do_reset();
        repeat (4) cycle(0, 0, 0, 0, 0);
        chk("idle_player_x", int'(player_x), 307);
        chk("idle_laser_active", int'(laser_active), 0);

        frames(10, 0, 1);
        chk("right10_player_x", int'(player_x), 327);
        frames(150, 0, 1);
        chk("right_sat_player_x", int'(player_x), 614);
        frames(3, 0, 1);
        chk("right_sat_hold", int'(player_x), 614);
        frames(5, 1, 1);
        chk("both_hold", int'(player_x), 614);

        do_reset();
        frames(153, 1, 0);
        chk("left_to_1", int'(player_x), 1);
        frames(1, 1, 0);
        chk("left_floor_0", int'(player_x), 0);
        frames(2, 1, 0);
        chk("left_no_wrap", int'(player_x), 0);

        do_reset();
        press_fire();
        frames(1, 0, 0);
        chk("spawn_active", int'(laser_active), 1);
        chk("spawn_x", int'(laser_x), 319);
        chk("spawn_y", int'(laser_y), 432);
        frames(108, 0, 0);
        chk("top_y", int'(laser_y), 0);
        chk("top_active", int'(laser_active), 1);
        frames(1, 0, 0);
        chk("off_top_active", int'(laser_active), 0);

        do_reset();
        press_fire();
        frames(1, 0, 0);
        press_fire();
        frames(120, 0, 0);
        chk("no_second_shot", int'(laser_active), 0);
        frames(3, 0, 0);
        chk("still_idle", int'(laser_active), 0);

        do_reset();
        press_fire();
        frames(84, 0, 0);
        chk("pre_hit_y", int'(laser_y), 100);
        cycle(0, 0, 0, 1, 1);
        chk("hit_active", int'(laser_active), 0);
        chk("hit_y", int'(laser_y), 100);
        chk("hit_x", int'(laser_x), 319);
        press_fire();
        frames(5, 0, 0);
        chk("refire_active", int'(laser_active), 1);
        do_reset();

        l = 0; r = 0; f = 0;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(7) == 0) l = ~l;
            if ($urandom_range(7) == 0) r = ~r;
            if ($urandom_range(5) == 0) f = ~f;
            cycle(l, r, f, ($urandom_range(3) == 0), ($urandom_range(15) == 0));
            if (i == 2500) begin
                do_reset();
                l = 0; r = 0; f = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
